// File: rtl/seq_match_window_counter.sv
// seq_match_window_counter
//
// Rate monitor for the serial sequence detector. Counts match pulses over
// back-to-back windows of WIN_LEN cycles and hands each completed window's
// count, plus a threshold flag, to the control/status logic through a
// one-entry valid/ready buffer.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   en           level-sensitive enable for windowed counting
//   match_in     match pulse from the sequence detector (one count per high cycle)
//   cnt_out      count of the last completed window (CNT_W bits, saturating)
//   over_thresh  cnt_out >= THRESH, meaningful while cnt_valid is high
//   cnt_valid    buffer holds an unconsumed result
//   cnt_ready    consumer accepts the result when cnt_valid && cnt_ready
//   drop         one-cycle pulse: a completed result was discarded (buffer full)
//
// Timing: en sampled high at edge k starts a window; match_in is sampled at
// edges k+1..k+WIN_LEN and the result is visible after edge k+WIN_LEN.
// Every output comes straight from a flop.

module seq_match_window_counter #(
  parameter int WIN_LEN = 16,
  parameter int CNT_W   = 8,
  parameter int THRESH  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             match_in,
  output logic [CNT_W-1:0] cnt_out,
  output logic             over_thresh,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             drop
);

  localparam int               W_W     = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam logic [W_W-1:0]   W_LAST  = W_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [W_W-1:0]   w, w_nxt;
  logic [CNT_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] win_count;
  logic             win_end;
  logic             consume;
  logic             load;
  logic             discard;

  // Saturating increment: once the accumulator is all ones it holds.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a,
                                               input logic             inc);
    if (inc && (a != CNT_MAX)) begin
      return a + CNT_W'(1);
    end
    return a;
  endfunction

  // Threshold compare for a freshly completed window.
  function automatic logic at_or_over(input logic [CNT_W-1:0] c);
    return (c >= THR);
  endfunction

  // Window sequencing: next state, window index and accumulator
  always_comb begin
    state_nxt = state;
    w_nxt     = w;
    acc_nxt   = acc;
    win_end   = 1'b0;
    // The final window count includes the match sampled on the closing edge.
    win_count = sat_inc(acc, match_in);

    unique case (state)
      IDLE: begin
        if (en) begin
          state_nxt = COUNT;
          w_nxt     = '0;
          acc_nxt   = '0;
        end
      end
      COUNT: begin
        if (w == W_LAST) begin
          // Window end: result is offered regardless of en; en only decides
          // whether the next window starts immediately (no gap cycle).
          win_end = 1'b1;
          w_nxt   = '0;
          acc_nxt = '0;
          if (!en) begin
            state_nxt = IDLE;
          end
        end else if (!en) begin
          // Abort mid-window: partial count is thrown away silently.
          state_nxt = IDLE;
          w_nxt     = '0;
          acc_nxt   = '0;
        end else begin
          w_nxt   = w + W_W'(1);
          acc_nxt = win_count;
        end
      end
      default: begin
        state_nxt = IDLE;
        w_nxt     = '0;
        acc_nxt   = '0;
      end
    endcase
  end

  assign consume = cnt_valid && cnt_ready;
  assign load    = win_end && (!cnt_valid || consume);
  assign discard = win_end && cnt_valid && !cnt_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      w     <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      w     <= w_nxt;
      acc   <= acc_nxt;
    end
  end

  // Output buffer: one entry, independent of en
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_out     <= '0;
      over_thresh <= 1'b0;
      cnt_valid   <= 1'b0;
      drop        <= 1'b0;
    end else begin
      drop <= discard;
      if (load) begin
        cnt_out     <= win_count;
        over_thresh <= at_or_over(win_count);
        cnt_valid   <= 1'b1;
      end else if (consume) begin
        // Data holds its last value; it is don't-care while cnt_valid is low.
        cnt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_match_window_counter.sv
// Testbench for seq_match_window_counter: directed table, hand-written
// multi-cycle sequences and randomized traffic against a window-level model.

module tb_seq_match_window_counter;

  localparam int WIN  = 8;
  localparam int CW   = 8;
  localparam int TH   = 3;
  localparam int SWIN = 12;
  localparam int SCW  = 3;
  localparam int STH  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic          rst = 1'b1, en = 1'b0, match_in = 1'b0, cnt_ready = 1'b0;
  logic [CW-1:0] cnt_out;
  logic          over_thresh, cnt_valid, drop;

  // saturation instance
  logic           s_rst = 1'b1, s_en = 1'b0, s_match = 1'b0, s_ready = 1'b0;
  logic [SCW-1:0] s_cnt;
  logic           s_over, s_valid, s_drop;

  seq_match_window_counter #(.WIN_LEN(WIN), .CNT_W(CW), .THRESH(TH)) dut (
    .clk(clk), .rst(rst), .en(en), .match_in(match_in),
    .cnt_out(cnt_out), .over_thresh(over_thresh), .cnt_valid(cnt_valid),
    .cnt_ready(cnt_ready), .drop(drop)
  );

  seq_match_window_counter #(.WIN_LEN(SWIN), .CNT_W(SCW), .THRESH(STH)) dut_sat (
    .clk(clk), .rst(s_rst), .en(s_en), .match_in(s_match),
    .cnt_out(s_cnt), .over_thresh(s_over), .cnt_valid(s_valid),
    .cnt_ready(s_ready), .drop(s_drop)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Keeps the whole match history; a window is identified by the edge that
  // started it, and its count is the (clipped) sum of the next WIN samples.
  bit mh [0:19999];
  int t      = 0;
  int start  = -1;
  bit mv     = 1'b0;
  int mc     = 0;
  bit mo     = 1'b0;
  bit md     = 1'b0;

  task automatic model_edge(input bit r, input bit e, input bit m, input bit rd);
    bit offer;
    bit consume;
    int sum;
    offer = 1'b0;
    sum   = 0;
    if (r) begin
      start = -1; mv = 1'b0; mc = 0; mo = 1'b0; md = 1'b0;
    end else begin
      mh[t] = m;
      if (start < 0) begin
        if (e) start = t;
      end else if (t - start == WIN) begin
        for (int i = start + 1; i <= t; i++) sum += int'(mh[i]);
        if (sum > (2 ** CW) - 1) sum = (2 ** CW) - 1;
        offer = 1'b1;
        start = e ? t : -1;
      end else if (!e) begin
        start = -1;
      end
      consume = mv && rd;
      md      = offer && mv && !rd;
      if (offer && (!mv || consume)) begin
        mc = sum; mo = (sum >= TH); mv = 1'b1;
      end else if (consume) begin
        mv = 1'b0;
      end
    end
    t++;
  endtask

  task automatic step(input bit r, input bit e, input bit m, input bit rd);
    rst = r; en = e; match_in = m; cnt_ready = rd;
    @(posedge clk);
    #1;
    model_edge(r, e, m, rd);
    chk("mdl_valid", cnt_valid, mv);
    chk("mdl_drop", drop, md);
    if (mv) begin
      chk("mdl_cnt", cnt_out, mc);
      chk("mdl_over", over_thresh, mo);
    end
  endtask

  // One full window; pattern bit i is match_in at window cycle i.
  task automatic run_win(input bit [WIN-1:0] pat, input bit en_last,
                         input bit rd_mid, input bit rd_last);
    for (int i = 0; i < WIN - 1; i++) step(1'b0, 1'b1, pat[i], rd_mid);
    step(1'b0, en_last, pat[WIN-1], rd_last);
  endtask

  task automatic s_step(input bit r, input bit e, input bit m);
    s_rst = r; s_en = e; s_match = m;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit r; bit e; bit m; bit rd;
    bit ev; int ec; bit eo; bit ed; bit cd;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Saturation: CNT_W=3, WIN_LEN=12, match high every window cycle
    s_step(1'b1, 1'b0, 1'b0);
    chk("sat_rst_valid", s_valid, 0);
    s_step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < SWIN - 1; i++) s_step(1'b0, 1'b1, 1'b1);
    chk("sat_valid_early", s_valid, 0);
    s_step(1'b0, 1'b0, 1'b1);
    chk("sat_valid", s_valid, 1);
    chk("sat_cnt", s_cnt, 7);
    chk("sat_over", s_over, 1);
    chk("sat_drop", s_drop, 0);

    // Directed table: reset, en from edge 1, matches at window cycles 0,3,4
    tbl[0]  = '{1, 0, 0, 0,  0, 0, 0, 0, 1};
    tbl[1]  = '{0, 1, 0, 0,  0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 1, 0,  0, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 0, 0,  0, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 0,  0, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 1, 0,  0, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 1, 0,  0, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 0, 0,  0, 0, 0, 0, 0};
    tbl[8]  = '{0, 1, 0, 0,  0, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0,  1, 3, 1, 0, 1};
    tbl[10] = '{0, 0, 0, 1,  0, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0,  0, 0, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].m, tbl[i].rd);
      chk("tbl_valid", cnt_valid, tbl[i].ev);
      chk("tbl_drop", drop, tbl[i].ed);
      if (tbl[i].ev || tbl[i].cd) begin
        chk("tbl_cnt", cnt_out, tbl[i].ec);
        chk("tbl_over", over_thresh, tbl[i].eo);
      end
    end

    // Back-to-back windows, 2 then 5 matches, including both boundary cycles
    step(1'b0, 1'b1, 1'b0, 1'b1);
    run_win(8'b1000_0001, 1'b1, 1'b1, 1'b1);
    chk("b2b_valid1", cnt_valid, 1);
    chk("b2b_cnt1", cnt_out, 2);
    chk("b2b_over1", over_thresh, 0);
    run_win(8'b1000_1111, 1'b0, 1'b1, 1'b1);
    chk("b2b_valid2", cnt_valid, 1);
    chk("b2b_cnt2", cnt_out, 5);
    chk("b2b_over2", over_thresh, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2b_drain", cnt_valid, 0);

    // Backpressure: 4 held, 1 dropped; then ready on a window-end edge
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_win(8'b0011_0011, 1'b1, 1'b0, 1'b0);
    chk("bp_cnt4", cnt_out, 4);
    run_win(8'b0100_0000, 1'b1, 1'b0, 1'b0);
    chk("bp_drop", drop, 1);
    chk("bp_hold_cnt", cnt_out, 4);
    chk("bp_hold_valid", cnt_valid, 1);
    run_win(8'b0000_0010, 1'b0, 1'b0, 1'b1);
    chk("bp_swap_cnt", cnt_out, 1);
    chk("bp_swap_valid", cnt_valid, 1);
    chk("bp_swap_drop", drop, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Abort at window cycle 5 after 3 matches, then a clean window
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b1);
      chk("abort_valid", cnt_valid, 0);
      chk("abort_drop", drop, 0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b1);
    run_win(8'b0000_0110, 1'b0, 1'b1, 1'b1);
    chk("abort_next_cnt", cnt_out, 2);
    chk("abort_next_over", over_thresh, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-window with a pending result
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_win(8'b1111_1111, 1'b1, 1'b0, 1'b0);
    chk("rst_pre_cnt", cnt_out, 8);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_valid", cnt_valid, 0);
    chk("rst_cnt", cnt_out, 0);
    chk("rst_over", over_thresh, 0);
    chk("rst_drop", drop, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_win(8'b0001_1001, 1'b0, 1'b0, 1'b0);
    chk("rst_after_valid", cnt_valid, 1);
    chk("rst_after_cnt", cnt_out, 3);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic against the model
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 9) != 0,
           1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
